// File: rtl/routing_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : routing_cfg_pkg
// Description : Shared types and helpers for the routing configuration loader.
//               Optional macro ROUTING_CFG_READBACK_EN adds the READBACK state.
// Revision    : 1.0 - initial release
// ============================================================================
package routing_cfg_pkg;

    // Select bits consumed by the routing block for each wire
    localparam int SEL_PER_WIRE = 12;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOAD     = 2'd1,
`ifdef ROUTING_CFG_READBACK_EN
        ST_GUARD    = 2'd2,
        ST_READBACK = 2'd3
`else
        ST_GUARD    = 2'd2
`endif
    } state_e;

    // Number of chunks needed to cover a select word (ceiling division)
    function automatic int calc_n_chunks(input int sel_w, input int chunk_w);
        return (sel_w + chunk_w - 1) / chunk_w;
    endfunction

    // Counter width able to index n items, never narrower than one bit
    function automatic int calc_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/routing_cfg_shadow.sv
`default_nettype none
// ============================================================================
// Module      : routing_cfg_shadow
// Description : Chunk-indexed shadow register. Chunk idx_i lands at bits
//               [idx_i*CHUNK_W +: CHUNK_W]; bits beyond SEL_W are dropped.
//               word_nxt_o shows the word with the pending write merged in.
// Revision    : 1.0 - initial release
// ============================================================================
module routing_cfg_shadow #(
    parameter int SEL_W   = 36,
    parameter int CHUNK_W = 4,
    parameter int IDX_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_i,
    input  logic               we_i,
    input  logic [IDX_W-1:0]   idx_i,
    input  logic [CHUNK_W-1:0] data_i,
    output logic [SEL_W-1:0]   word_o,
    output logic [SEL_W-1:0]   word_nxt_o
);

    logic [SEL_W-1:0] shadow_q;
    logic [SEL_W-1:0] w_word_d;

    // Merge the incoming chunk bit by bit so a partial last chunk is clipped
    always_comb begin
        w_word_d = shadow_q;
        if (we_i) begin
            for (int i = 0; i < SEL_W; i++) begin
                if ((i / CHUNK_W) == int'(idx_i)) begin
                    w_word_d[i] = data_i[i % CHUNK_W];
                end
            end
        end
    end

    // Shadow storage; clear discards a partially assembled word
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            shadow_q <= '0;
        end else if (we_i) begin
            shadow_q <= w_word_d;
        end
    end

    assign word_o     = shadow_q;
    assign word_nxt_o = w_word_d;

endmodule
`default_nettype wire

// File: rtl/routing_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module      : routing_cfg_loader
// Description : Streams the routing select word in CHUNK_W pieces, checks
//               framing, then applies it break-before-make (select held at 0
//               for GUARD_CYCLES cycles before the new word goes live).
//               Define ROUTING_CFG_READBACK_EN to add chunked readback of the
//               active select word.
// Revision    : 1.0 - initial release
// ============================================================================
module routing_cfg_loader
    import routing_cfg_pkg::*;
#(
    parameter  int WIRE_WIDTH   = 3,
    parameter  int CHUNK_W      = 4,
    parameter  int GUARD_CYCLES = 2,
    localparam int SEL_W        = WIRE_WIDTH * SEL_PER_WIRE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid_i,
    output logic               cfg_ready_o,
    input  logic [CHUNK_W-1:0] cfg_data_i,
    input  logic               cfg_last_i,
`ifdef ROUTING_CFG_READBACK_EN
    input  logic               rb_req_i,
    output logic               rb_valid_o,
    output logic [CHUNK_W-1:0] rb_data_o,
    output logic               rb_last_o,
`endif
    output logic [SEL_W-1:0]   select_o,
    output logic               busy_o,
    output logic               cfg_done_o,
    output logic               cfg_err_o
);

    localparam int N_CHUNKS = calc_n_chunks(SEL_W, CHUNK_W);
    localparam int IDX_W    = calc_idx_w(N_CHUNKS);
    localparam int GW       = calc_idx_w(GUARD_CYCLES);

    state_e             state_q;
    logic [IDX_W-1:0]   cnt_q;
    logic [GW-1:0]      guard_q;
    logic [SEL_W-1:0]   select_q;
    logic               ready_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;

    logic               w_rb_take;
    logic               w_xfer;
    logic               w_is_final;
    logic               w_frame_err;
    logic [SEL_W-1:0]   w_shadow;
    logic [SEL_W-1:0]   w_shadow_nxt;

`ifdef ROUTING_CFG_READBACK_EN
    localparam int PAD_W = N_CHUNKS * CHUNK_W;

    logic               rb_valid_q;
    logic [CHUNK_W-1:0] rb_data_q;
    logic               rb_last_q;
    logic [PAD_W-1:0]   w_sel_pad;

    // A readback request in IDLE wins over a chunk offered the same cycle
    assign w_rb_take = rb_req_i && (state_q == ST_IDLE);
    assign w_sel_pad = PAD_W'(select_q);
`else
    assign w_rb_take = 1'b0;
`endif

    assign w_xfer      = cfg_valid_i && ready_q && !w_rb_take;
    assign w_is_final  = (cnt_q == IDX_W'(N_CHUNKS - 1));
    assign w_frame_err = w_xfer && (cfg_last_i != w_is_final);

    routing_cfg_shadow #(
        .SEL_W   (SEL_W),
        .CHUNK_W (CHUNK_W),
        .IDX_W   (IDX_W)
    ) u_shadow (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (w_frame_err),
        .we_i       (w_xfer && !w_frame_err),
        .idx_i      (cnt_q),
        .data_i     (cfg_data_i),
        .word_o     (w_shadow),
        .word_nxt_o (w_shadow_nxt)
    );

    // Loader FSM: chunk counting, framing, guard timing and output register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            guard_q  <= '0;
            select_q <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef ROUTING_CFG_READBACK_EN
            rb_valid_q <= 1'b0;
            rb_data_q  <= '0;
            rb_last_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE, ST_LOAD: begin
`ifdef ROUTING_CFG_READBACK_EN
                    if (w_rb_take) begin
                        state_q    <= ST_READBACK;
                        ready_q    <= 1'b0;
                        busy_q     <= 1'b1;
                        rb_valid_q <= 1'b1;
                        rb_data_q  <= w_sel_pad[0 +: CHUNK_W];
                        rb_last_q  <= (N_CHUNKS == 1);
                        cnt_q      <= IDX_W'(1);
                    end else
`endif
                    if (w_xfer) begin
                        if (w_frame_err) begin
                            err_q   <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= ST_IDLE;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end else if (w_is_final) begin
                            cnt_q <= '0;
                            if (GUARD_CYCLES > 0) begin
                                // Break: open every switch before the new word
                                select_q <= '0;
                                guard_q  <= GW'(GUARD_CYCLES - 1);
                                state_q  <= ST_GUARD;
                                ready_q  <= 1'b0;
                                busy_q   <= 1'b1;
                            end else begin
                                select_q <= w_shadow_nxt;
                                done_q   <= 1'b1;
                                state_q  <= ST_IDLE;
                                ready_q  <= 1'b1;
                                busy_q   <= 1'b0;
                            end
                        end else begin
                            cnt_q   <= cnt_q + IDX_W'(1);
                            state_q <= ST_LOAD;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ST_GUARD: begin
                    if (guard_q == '0) begin
                        // Make: the assembled word goes live
                        select_q <= w_shadow;
                        done_q   <= 1'b1;
                        state_q  <= ST_IDLE;
                        ready_q  <= 1'b1;
                        busy_q   <= 1'b0;
                    end else begin
                        guard_q <= guard_q - GW'(1);
                    end
                end
`ifdef ROUTING_CFG_READBACK_EN
                ST_READBACK: begin
                    if (rb_last_q) begin
                        rb_valid_q <= 1'b0;
                        rb_data_q  <= '0;
                        rb_last_q  <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= ST_IDLE;
                        ready_q    <= 1'b1;
                        busy_q     <= 1'b0;
                    end else begin
                        rb_data_q <= w_sel_pad[cnt_q * CHUNK_W +: CHUNK_W];
                        rb_last_q <= (cnt_q == IDX_W'(N_CHUNKS - 1));
                        cnt_q     <= cnt_q + IDX_W'(1);
                    end
                end
`endif
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_ready_o = ready_q;
    assign busy_o      = busy_q;
    assign select_o    = select_q;
    assign cfg_done_o  = done_q;
    assign cfg_err_o   = err_q;
`ifdef ROUTING_CFG_READBACK_EN
    assign rb_valid_o  = rb_valid_q;
    assign rb_data_o   = rb_data_q;
    assign rb_last_o   = rb_last_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_routing_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_routing_cfg_loader
// Description : Directed self-checking bench for routing_cfg_loader. Runs a
//               GUARD_CYCLES=2 instance and a GUARD_CYCLES=0 instance on the
//               same stimulus. Readback checks need ROUTING_CFG_READBACK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_routing_cfg_loader;

    localparam logic [35:0] C_WORD_A = 36'h987654321;
    localparam logic [35:0] C_WORD_5 = 36'h555555555;
    localparam logic [35:0] C_WORD_X = 36'hAAAAAAAAA;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic [3:0]  cfg_data;
    logic        cfg_last;
    logic        rb_req;

    logic        cfg_ready, busy, cfg_done, cfg_err;
    logic [35:0] sel;
    logic        cfg_ready0, busy0, cfg_done0, cfg_err0;
    logic [35:0] sel0;
    logic        rb_valid, rb_last, rb_valid0, rb_last0;
    logic [3:0]  rb_data, rb_data0;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    routing_cfg_loader #(.WIRE_WIDTH(3), .CHUNK_W(4), .GUARD_CYCLES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid_i (cfg_valid),
        .cfg_ready_o (cfg_ready),
        .cfg_data_i  (cfg_data),
        .cfg_last_i  (cfg_last),
`ifdef ROUTING_CFG_READBACK_EN
        .rb_req_i    (rb_req),
        .rb_valid_o  (rb_valid),
        .rb_data_o   (rb_data),
        .rb_last_o   (rb_last),
`endif
        .select_o    (sel),
        .busy_o      (busy),
        .cfg_done_o  (cfg_done),
        .cfg_err_o   (cfg_err)
    );

    routing_cfg_loader #(.WIRE_WIDTH(3), .CHUNK_W(4), .GUARD_CYCLES(0)) dut0 (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid_i (cfg_valid),
        .cfg_ready_o (cfg_ready0),
        .cfg_data_i  (cfg_data),
        .cfg_last_i  (cfg_last),
`ifdef ROUTING_CFG_READBACK_EN
        .rb_req_i    (rb_req),
        .rb_valid_o  (rb_valid0),
        .rb_data_o   (rb_data0),
        .rb_last_o   (rb_last0),
`endif
        .select_o    (sel0),
        .busy_o      (busy0),
        .cfg_done_o  (cfg_done0),
        .cfg_err_o   (cfg_err0)
    );

`ifndef ROUTING_CFG_READBACK_EN
    assign rb_valid  = 1'b0;
    assign rb_data   = 4'h0;
    assign rb_last   = 1'b0;
    assign rb_valid0 = 1'b0;
    assign rb_data0  = 4'h0;
    assign rb_last0  = 1'b0;
`endif

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] d, input logic l);
        cfg_valid = 1'b1;
        cfg_data  = d;
        cfg_last  = l;
        tick();
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
    endtask

    task automatic load_const(input logic [3:0] d);
        for (int k = 0; k < 9; k++) send(d, k == 8);
    endtask

    task automatic load_ramp();
        for (int k = 0; k < 9; k++) send(4'(k + 1), k == 8);
    endtask

    // Hard stop if something never returns
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_data = 4'h0; cfg_last = 1'b0; rb_req = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // 1. reset state
        check_eq("rst_select",   64'(sel),       64'h0);
        check_eq("rst_ready",    64'(cfg_ready), 64'h1);
        check_eq("rst_busy",     64'(busy),      64'h0);
        check_eq("rst_done",     64'(cfg_done),  64'h0);
        check_eq("rst_err",      64'(cfg_err),   64'h0);
        check_eq("rst_rb_valid", 64'(rb_valid),  64'h0);

        // 2. back-to-back load, guard timing
        for (int k = 0; k < 9; k++) begin
            send(4'(k + 1), k == 8);
            if (k == 0) check_eq("load_busy", 64'(busy), 64'h1);
        end
        check_eq("g2_t1_select", 64'(sel),        64'h0);
        check_eq("g2_t1_ready",  64'(cfg_ready),  64'h0);
        check_eq("g2_t1_done",   64'(cfg_done),   64'h0);
        check_eq("g0_t1_select", 64'(sel0),       64'(C_WORD_A));
        check_eq("g0_t1_done",   64'(cfg_done0),  64'h1);
        check_eq("g0_t1_ready",  64'(cfg_ready0), 64'h1);
        tick();
        check_eq("g2_t2_select", 64'(sel),        64'h0);
        check_eq("g2_t2_busy",   64'(busy),       64'h1);
        check_eq("g0_t2_done",   64'(cfg_done0),  64'h0);
        tick();
        check_eq("g2_t3_select", 64'(sel),        64'(C_WORD_A));
        check_eq("g2_t3_done",   64'(cfg_done),   64'h1);
        check_eq("g2_t3_ready",  64'(cfg_ready),  64'h1);
        check_eq("g2_t3_busy",   64'(busy),       64'h0);
        tick();
        check_eq("g2_t4_done",   64'(cfg_done),   64'h0);

        // 3. early cfg_last on chunk 5
        for (int k = 0; k < 6; k++) begin
            send(4'hF, k == 5);
            if (k == 2) check_eq("midload_select", 64'(sel), 64'(C_WORD_A));
        end
        check_eq("early_err",    64'(cfg_err),  64'h1);
        check_eq("early_err0",   64'(cfg_err0), 64'h1);
        check_eq("early_select", 64'(sel),      64'(C_WORD_A));
        check_eq("early_done",   64'(cfg_done), 64'h0);
        check_eq("early_busy",   64'(busy),     64'h0);
        tick();
        check_eq("early_err_1c", 64'(cfg_err),  64'h0);
        check_eq("early_done2",  64'(cfg_done), 64'h0);

        // missing cfg_last on chunk 8
        for (int k = 0; k < 9; k++) send(4'hE, 1'b0);
        check_eq("nolast_err",    64'(cfg_err), 64'h1);
        check_eq("nolast_select", 64'(sel0),    64'(C_WORD_A));
        tick();

        // 4. a different word, then the ramp word with valid gaps
        load_const(4'h5);
        tick(); tick();
        check_eq("w5_select",  64'(sel),  64'(C_WORD_5));
        check_eq("w5_select0", 64'(sel0), 64'(C_WORD_5));
        tick();
        for (int k = 0; k < 9; k++) begin
            for (int g = 0; g < (k % 3); g++) tick();
            if (k == 4) begin
                check_eq("gap_busy",   64'(busy),  64'h1);
                check_eq("gap_select", 64'(sel),   64'(C_WORD_5));
                check_eq("gap_ready",  64'(cfg_ready), 64'h1);
            end
            send(4'(k + 1), k == 8);
        end
        check_eq("gap_g0_t1_select", 64'(sel0),      64'(C_WORD_A));
        check_eq("gap_g0_t1_done",   64'(cfg_done0), 64'h1);
        check_eq("gap_g2_t1_select", 64'(sel),       64'h0);
        tick(); tick();
        check_eq("gap_g2_t3_select", 64'(sel),       64'(C_WORD_A));
        check_eq("gap_g2_t3_done",   64'(cfg_done),  64'h1);
        tick();

        // 5. reset mid-load, then a clean load
        for (int k = 0; k < 4; k++) send(4'h3, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("midrst_select",  64'(sel),       64'h0);
        check_eq("midrst_select0", 64'(sel0),      64'h0);
        check_eq("midrst_busy",    64'(busy),      64'h0);
        check_eq("midrst_ready",   64'(cfg_ready), 64'h1);
        load_const(4'hA);
        check_eq("xa_g0_select", 64'(sel0), 64'(C_WORD_X));
        check_eq("xa_err",       64'(cfg_err), 64'h0);
        tick(); tick();
        check_eq("xa_g2_select", 64'(sel),  64'(C_WORD_X));
        tick();

`ifdef ROUTING_CFG_READBACK_EN
        // 6. readback of the ramp word; request collides with a chunk
        load_ramp();
        tick(); tick(); tick();
        check_eq("rb_pre_select", 64'(sel), 64'(C_WORD_A));
        rb_req    = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = 4'hF;
        cfg_last  = 1'b0;
        tick();
        rb_req    = 1'b0;
        cfg_valid = 1'b0;
        for (int k = 0; k < 9; k++) begin
            check_eq("rb_valid", 64'(rb_valid),  64'h1);
            check_eq("rb_data",  64'(rb_data),   64'(k + 1));
            check_eq("rb_last",  64'(rb_last),   64'(k == 8));
            check_eq("rb_ready", 64'(cfg_ready), 64'h0);
            check_eq("rb_busy",  64'(busy),      64'h1);
            tick();
        end
        check_eq("rb_end_valid", 64'(rb_valid),  64'h0);
        check_eq("rb_end_ready", 64'(cfg_ready), 64'h1);
        check_eq("rb_end_busy",  64'(busy),      64'h0);
        check_eq("rb_select",    64'(sel),       64'(C_WORD_A));
        // colliding chunk must not have been taken: a fresh word frames cleanly
        load_const(4'h5);
        check_eq("rb_after_err", 64'(cfg_err), 64'h0);
        tick(); tick();
        check_eq("rb_after_select", 64'(sel), 64'(C_WORD_5));
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
